sobel_scan_ctrl: RTL and testbench
==================================

Name: sobel_scan_ctrl

Overview:
Frame-scan sequencer for the Sobel kernel datapath. On `start` it walks every interior output pixel of an IMG_W x IMG_H 8-bit image held in a 1-cycle-latency read memory. For each column it fetches the three vertically adjacent pixels and presents them to the kernel as one column. It pairs each kernel result with its destination address and writes it to the output frame buffer. It sits between the image ROM, the Sobel kernel and the output/VGA frame buffer.

Parameters:
IMG_W, 224, image width in pixels (>=3)
IMG_H, 224, image height in pixels (>=3)
AW, 16, address width; IMG_W*IMG_H <= 2**AW
DW, 8, pixel width

Ports:
fclk  in  1  clock; all logic on posedge
rst  in  1  synchronous active-high reset
start  in  1  frame start request; sampled only in IDLE
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse when the frame is complete
rd_addr  out  AW  image memory read address
rd_en  out  1  read strobe; rd_data is valid on the cycle after rd_en
rd_data  in  DW  image memory read data
col_top  out  DW  pixel (y-1, c) to the kernel
col_mid  out  DW  pixel (y, c) to the kernel
col_bot  out  DW  pixel (y+1, c) to the kernel
col_valid  out  1  one-cycle strobe: column outputs are valid
row_start  out  1  asserted with col_valid for c=0; kernel clears its window
k_result  in  DW  kernel output magnitude
k_valid  in  1  kernel result strobe; must arrive 1..3 cycles after the col_valid that completes the window
wr_addr  out  AW  output buffer write address
wr_data  out  DW  output buffer write data
wr_en  out  1  write strobe
err  out  1  sticky error flag; cleared only by rst

Behaviour:
- Reset:
  - All outputs are 0; state is IDLE.
  - Row counter y=1, column counter c=0.
  - The pending-write slot is empty.
  - Reset mid-frame abandons the frame immediately; no done pulse is generated.
- States: IDLE -> FETCH_T -> FETCH_M -> FETCH_B -> PUSH -> (FETCH_T | DRAIN) ; DRAIN -> [BORDER] -> DONE -> IDLE.
- IDLE:
  - start=1 moves to FETCH_T next cycle and sets busy.
  - start in any other state is ignored.
- FETCH_T: rd_en=1, rd_addr=(y-1)*IMG_W+c.
- FETCH_M: rd_en=1, rd_addr=y*IMG_W+c; capture rd_data into the top register.
- FETCH_B: rd_en=1, rd_addr=(y+1)*IMG_W+c; capture rd_data into the mid register.
- PUSH:
  - Capture rd_data into bot.
  - Assert col_valid for one cycle with top/mid/bot; row_start=1 iff c=0.
  - If c>=2, load the pending slot with address y*IMG_W+(c-1).
  - Advance: c wraps at IMG_W-1 to 0 with y+1. After c=IMG_W-1 on y=IMG_H-2, go to DRAIN; otherwise go to FETCH_T.
- Rate: exactly 4 cycles per column, 4*IMG_W*(IMG_H-2) cycles for the scan.
- Addresses are computed with row-base accumulators (add IMG_W per row), not multipliers.
- Write path:
  - On k_valid with the pending slot full: in the same cycle, wr_en=1, wr_addr=slot, wr_data=k_result; the slot empties.
  - k_valid with the slot empty: no write; err set.
  - Pending slot reloaded while still full (result missing): err set; the old address is overwritten.
- DRAIN:
  - Waits until the slot empties, max 3 cycles.
  - If still full after 3 cycles, set err, discard the slot, and proceed.
- DONE: done=1 for one cycle, busy=0 in the same cycle, then IDLE.
- A start asserted on the DONE cycle is not accepted; it is accepted from IDLE on the following cycle.
- Border pixels (row 0, row IMG_H-1, col 0, col IMG_W-1) are never written unless the optional feature is enabled.

Optional Feature:
Macro SOBEL_BORDER_ZERO_EN.
- With the macro:
  - BORDER state, entered after DRAIN, writes wr_data=0 to every border pixel, one per cycle.
  - Order: row 0 left to right, row IMG_H-1 left to right, then col 0 and col IMG_W-1 for rows 1..IMG_H-2, top to bottom, alternating left/right.
  - That is 2*IMG_W+2*(IMG_H-2) writes, then DONE.
- Without the macro: the BORDER state does not exist; DRAIN goes straight to DONE.

Decomposition:
- Package sobel_pkg: IMG_W/IMG_H/AW/DW defaults, state enum (IDLE, FETCH_T, FETCH_M, FETCH_B, PUSH, DRAIN, BORDER, DONE), and PIX_PER_FRAME constant.
- Sub-module sobel_addr_gen: row/column counters and the three row-base accumulators, with step/clear inputs. It is reused for the border walk.

Test Plan:
1. IMG_W=5, IMG_H=4, ROM pixel=address; model kernel echoes col_mid after 1 cycle -> 6 writes to addresses 6,7,8,11,12,13 with data equal to their own address; done 1 cycle after the last write; busy high for exactly 4*5*2+drain cycles.
2. Read sequence check, same config -> first 12 rd_addr values are 0,5,10,1,6,11,2,7,12,3,8,13; row_start high only at the 1st and 6th col_valid.
3. Kernel latency 3 vs 1 -> identical write address/data sequence; err stays 0.
4. Kernel never asserts k_valid -> zero writes, err=1, done still pulses.
5. rst asserted at cycle 17 of a frame -> all outputs 0 next cycle, no done pulse; a new start replays the full frame correctly.
6. SOBEL_BORDER_ZERO_EN defined, 5x4 -> 14 zero writes after the interior writes, first to addresses 0..4, then 15..19, then 5,9,10,14; then done.

Source files
------------

// File: rtl/sobel_scan_ctrl_pkg.sv
// Shared constants and state encodings for the Sobel frame-scan sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package sobel_pkg;

  localparam int IMG_W_DEF     = 224;
  localparam int IMG_H_DEF     = 224;
  localparam int AW_DEF        = 16;
  localparam int DW_DEF        = 8;
  localparam int PIX_PER_FRAME = IMG_W_DEF * IMG_H_DEF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH_T = 3'd1,
    FETCH_M = 3'd2,
    FETCH_B = 3'd3,
    PUSH    = 3'd4,
    DRAIN   = 3'd5,
    BORDER  = 3'd6,
    DONE    = 3'd7
  } state_t;

  // Sub-phases of the border zero-fill walk.
  typedef enum logic [1:0] {
    BP_TOP  = 2'd0,
    BP_BOT  = 2'd1,
    BP_SIDE = 2'd2
  } bphase_t;

endpackage

// File: rtl/sobel_scan_ctrl_if.sv
// Bundle of control, image-read, kernel and frame-buffer-write signals.
// Latency: none (wiring only).
// Backpressure: none; the kernel must answer within its fixed latency window.
interface sobel_scan_ctrl_if #(
  parameter int AW = 16,
  parameter int DW = 8
);

  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] rd_addr;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] col_top;
  logic [DW-1:0] col_mid;
  logic [DW-1:0] col_bot;
  logic          col_valid;
  logic          row_start;
  logic [DW-1:0] k_result;
  logic          k_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic          err;

  // Sequencer side.
  modport master (
    input  start, rd_data, k_result, k_valid,
    output busy, done, rd_addr, rd_en, col_top, col_mid, col_bot,
           col_valid, row_start, wr_addr, wr_data, wr_en, err
  );

  // Environment side: memory, kernel, frame buffer and controller.
  modport slave (
    output start, rd_data, k_result, k_valid,
    input  busy, done, rd_addr, rd_en, col_top, col_mid, col_bot,
           col_valid, row_start, wr_addr, wr_data, wr_en, err
  );

endinterface

// File: rtl/sobel_scan_ctrl_addr_gen.sv
// Row/column counters with three row-base accumulators (rows y-1, y, y+1).
// Latency: counters update on the clock after a step/clear request.
// Backpressure: none; steps are issued by the owning FSM only.
module sobel_addr_gen #(
  parameter int IMG_W = 224,
  parameter int IMG_H = 224,
  parameter int AW    = 16
) (
  input  logic          fclk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_step_col,
  input  logic          i_step_row,
  output logic [AW-1:0] o_c,
  output logic [AW-1:0] o_base_t,
  output logic [AW-1:0] o_base_m,
  output logic [AW-1:0] o_base_b,
  output logic          o_last_col,
  output logic          o_last_row
);

  localparam logic [AW-1:0] W_A    = AW'(IMG_W);
  localparam logic [AW-1:0] W2_A   = AW'(2 * IMG_W);
  localparam logic [AW-1:0] LAST_C = AW'(IMG_W - 1);
  localparam logic [AW-1:0] LAST_R = AW'(IMG_H - 2);

  logic [AW-1:0] r_c;
  logic [AW-1:0] r_y;
  logic [AW-1:0] r_base_t;
  logic [AW-1:0] r_base_m;
  logic [AW-1:0] r_base_b;

  // Counters restart at (y=1, c=0); row bases advance by one image width per row.
  always_ff @(posedge fclk) begin
    if (rst || i_clear) begin
      r_c      <= '0;
      r_y      <= AW'(1);
      r_base_t <= '0;
      r_base_m <= W_A;
      r_base_b <= W2_A;
    end else begin
      if (i_step_col) begin
        r_c <= (r_c == LAST_C) ? '0 : r_c + AW'(1);
      end
      if (i_step_row) begin
        r_y      <= r_y + AW'(1);
        r_base_t <= r_base_t + W_A;
        r_base_m <= r_base_m + W_A;
        r_base_b <= r_base_b + W_A;
      end
    end
  end

  assign o_c        = r_c;
  assign o_base_t   = r_base_t;
  assign o_base_m   = r_base_m;
  assign o_base_b   = r_base_b;
  assign o_last_col = (r_c == LAST_C);
  assign o_last_row = (r_y == LAST_R);

endmodule

// File: rtl/sobel_scan_ctrl.sv
// Sobel frame-scan sequencer: fetches 3-pixel columns, pairs kernel results with addresses.
// Latency: 4 cycles per column; write issued in the same cycle as k_valid.
// Backpressure: none; optional border zero-fill under SOBEL_BORDER_ZERO_EN.
module sobel_scan_ctrl
  import sobel_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic              fclk,
  input  logic              rst,
  sobel_scan_ctrl_if.master bus
);

  state_t        r_state;
  state_t        w_next;
  logic [DW-1:0] r_top;
  logic [DW-1:0] r_mid;
  logic [DW-1:0] r_bot;
  logic [AW-1:0] r_slot;
  logic          r_full;
  logic          r_err;
  logic [1:0]    r_drain_cnt;

  logic          w_rd_en;
  logic [AW-1:0] w_rd_addr;
  logic          w_col_valid;
  logic          w_load;
  logic          w_bwr;
  logic [AW-1:0] w_baddr;
  logic          w_kwr;
  logic          w_drain_exit;
  logic          w_timeout;

  logic          w_clear;
  logic          w_step_col;
  logic          w_step_row;
  logic [AW-1:0] w_c;
  logic [AW-1:0] w_base_t;
  logic [AW-1:0] w_base_m;
  logic [AW-1:0] w_base_b;
  logic          w_last_col;
  logic          w_last_row;

  sobel_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .AW    (AW)
  ) u_addr (
    .fclk       (fclk),
    .rst        (rst),
    .i_clear    (w_clear),
    .i_step_col (w_step_col),
    .i_step_row (w_step_row),
    .o_c        (w_c),
    .o_base_t   (w_base_t),
    .o_base_m   (w_base_m),
    .o_base_b   (w_base_b),
    .o_last_col (w_last_col),
    .o_last_row (w_last_row)
  );

  // The final result can trail the last column by up to 3 cycles.
  assign w_drain_exit = (r_state == DRAIN) &&
                        (!r_full || bus.k_valid || (r_drain_cnt == 2'd2));
  assign w_timeout    = (r_state == DRAIN) && r_full && !bus.k_valid &&
                        (r_drain_cnt == 2'd2);
  assign w_kwr        = bus.k_valid && r_full;

`ifdef SOBEL_BORDER_ZERO_EN
  localparam logic [AW-1:0] L_WM1 = AW'(IMG_W - 1);

  bphase_t r_bphase;
  logic    r_side;

  // Border walk: top row, bottom row, then left/right pairs for the middle rows.
  always_ff @(posedge fclk) begin
    if (rst || (r_state == DRAIN)) begin
      r_bphase <= BP_TOP;
      r_side   <= 1'b0;
    end else if (r_state == BORDER) begin
      case (r_bphase)
        BP_TOP:  if (w_last_col) r_bphase <= BP_BOT;
        BP_BOT:  if (w_last_col) r_bphase <= BP_SIDE;
        default: r_side <= ~r_side;
      endcase
    end
  end
`endif

  // State register.
  always_ff @(posedge fclk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode plus read, column and counter-step controls.
  always_comb begin
    w_next      = r_state;
    w_rd_en     = 1'b0;
    w_rd_addr   = '0;
    w_clear     = 1'b0;
    w_step_col  = 1'b0;
    w_step_row  = 1'b0;
    w_load      = 1'b0;
    w_col_valid = 1'b0;
    w_bwr       = 1'b0;
    w_baddr     = '0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_next  = FETCH_T;
          w_clear = 1'b1;
        end
      end
      FETCH_T: begin
        w_rd_en   = 1'b1;
        w_rd_addr = w_base_t + w_c;
        w_next    = FETCH_M;
      end
      FETCH_M: begin
        w_rd_en   = 1'b1;
        w_rd_addr = w_base_m + w_c;
        w_next    = FETCH_B;
      end
      FETCH_B: begin
        w_rd_en   = 1'b1;
        w_rd_addr = w_base_b + w_c;
        w_next    = PUSH;
      end
      PUSH: begin
        w_col_valid = 1'b1;
        w_load      = (w_c >= AW'(2));
        w_step_col  = 1'b1;
        // The last row is left un-stepped so the border walk finds y = IMG_H-2.
        if (w_last_col && w_last_row) begin
          w_next = DRAIN;
        end else begin
          w_next     = FETCH_T;
          w_step_row = w_last_col;
        end
      end
      DRAIN: begin
        if (w_drain_exit) begin
`ifdef SOBEL_BORDER_ZERO_EN
          w_next = BORDER;
`else
          w_next = DONE;
`endif
        end
      end
`ifdef SOBEL_BORDER_ZERO_EN
      BORDER: begin
        w_bwr = 1'b1;
        case (r_bphase)
          BP_TOP: begin
            w_baddr    = w_c;
            w_step_col = 1'b1;
          end
          BP_BOT: begin
            w_baddr    = w_base_b + w_c;
            w_step_col = 1'b1;
            w_clear    = w_last_col;
          end
          default: begin
            w_baddr = r_side ? (w_base_m + L_WM1) : w_base_m;
            if (r_side) begin
              if (w_last_row) w_next = DONE;
              else            w_step_row = 1'b1;
            end
          end
        endcase
      end
`endif
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Column pixel capture as read data returns.
  always_ff @(posedge fclk) begin
    if (rst) begin
      r_top <= '0;
      r_mid <= '0;
      r_bot <= '0;
    end else begin
      if (r_state == FETCH_M) r_top <= bus.rd_data;
      if (r_state == FETCH_B) r_mid <= bus.rd_data;
      if (r_state == PUSH)    r_bot <= bus.rd_data;
    end
  end

  // Pending-write slot and sticky error tracking.
  always_ff @(posedge fclk) begin
    if (rst) begin
      r_slot <= '0;
      r_full <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (w_load) begin
        r_slot <= w_base_m + w_c - AW'(1);
        r_full <= 1'b1;
      end else if (w_kwr || w_timeout) begin
        r_full <= 1'b0;
      end
      if ((bus.k_valid && !r_full) || (w_load && r_full && !bus.k_valid) || w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  // Cycles spent waiting in DRAIN.
  always_ff @(posedge fclk) begin
    if (rst)                    r_drain_cnt <= '0;
    else if (r_state == DRAIN)  r_drain_cnt <= r_drain_cnt + 2'd1;
    else                        r_drain_cnt <= '0;
  end

  assign bus.busy      = (r_state != IDLE) && (r_state != DONE);
  assign bus.done      = (r_state == DONE);
  assign bus.rd_en     = w_rd_en;
  assign bus.rd_addr   = w_rd_addr;
  assign bus.col_top   = r_top;
  assign bus.col_mid   = r_mid;
  assign bus.col_bot   = (r_state == PUSH) ? bus.rd_data : r_bot;
  assign bus.col_valid = w_col_valid;
  assign bus.row_start = w_col_valid && (w_c == '0);
  assign bus.wr_en     = w_bwr || w_kwr;
  assign bus.wr_addr   = w_bwr ? w_baddr : (w_kwr ? r_slot : '0);
  assign bus.wr_data   = w_kwr ? bus.k_result : '0;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_sobel_scan_ctrl.sv
// Scoreboard bench for sobel_scan_ctrl on a 5x4 image with a pixel=address ROM.
// Latency: kernel model answers 1 or 3 cycles after the completing column.
// Backpressure: none; the monitor pops expected reads/columns/writes as they appear.
module tb_sobel_scan_ctrl;

  localparam int W  = 5;
  localparam int H  = 4;
  localparam int AW = 16;
  localparam int DW = 8;
`ifdef SOBEL_BORDER_ZERO_EN
  localparam int BORDER_CYC = 2 * W + 2 * (H - 2);
`else
  localparam int BORDER_CYC = 0;
`endif

  logic fclk = 1'b0;
  logic rst  = 1'b1;
  always #5 fclk = ~fclk;

  sobel_scan_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  sobel_scan_ctrl #(
    .IMG_W (W),
    .IMG_H (H),
    .AW    (AW),
    .DW    (DW)
  ) dut (
    .fclk (fclk),
    .rst  (rst),
    .bus  (bus)
  );

  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct packed { logic rs; logic [DW-1:0] t; logic [DW-1:0] m; logic [DW-1:0] b; } cv_t;

  wr_t           wr_q[$];
  logic [AW-1:0] rd_q[$];
  cv_t           cv_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0, busy_cnt = 0, done_cnt = 0, done_cyc = 0, last_wr_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h with nothing expected", name, act);
  endtask

  // Image ROM: pixel value equals the low byte of its address, 1-cycle latency.
  always @(posedge fclk) if (bus.rd_en) bus.rd_data <= bus.rd_addr[DW-1:0];

  // Kernel model: echoes the centre column's mid pixel once a 3-column window fills.
  int            lat = 1;
  bit            ken = 1'b1;
  logic [2:0]    kv;
  logic [DW-1:0] kd0, kd1, kd2, prev_mid;
  int            ncol;
  always @(posedge fclk) begin
    if (rst) begin
      kv   <= '0;
      ncol <= 0;
    end else begin
      kv  <= {kv[1:0], 1'b0};
      kd1 <= kd0;
      kd2 <= kd1;
      if (bus.col_valid) begin
        prev_mid <= bus.col_mid;
        if (bus.row_start) ncol <= 1;
        else begin
          ncol <= ncol + 1;
          if (ncol >= 2) begin
            kv[0] <= 1'b1;
            kd0   <= prev_mid;
          end
        end
      end
    end
  end
  assign bus.k_valid  = ken && ((lat == 1) ? kv[0] : (lat == 2) ? kv[1] : kv[2]);
  assign bus.k_result = (lat == 1) ? kd0 : (lat == 2) ? kd1 : kd2;

  // Monitor: compares every read, column and write against the queues.
  always @(negedge fclk) begin
    cyc++;
    if (!rst) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.rd_en) begin
        if (rd_q.size() == 0) unexpected("rd_addr", 32'(bus.rd_addr));
        else chk("rd_addr", 32'(bus.rd_addr), 32'(rd_q.pop_front()));
      end
      if (bus.col_valid) begin
        if (cv_q.size() == 0) unexpected("col", 32'(bus.col_mid));
        else begin
          cv_t e;
          e = cv_q.pop_front();
          chk("row_start", 32'(bus.row_start), 32'(e.rs));
          chk("col_pix", {8'h0, bus.col_top, bus.col_mid, bus.col_bot}, {8'h0, e.t, e.m, e.b});
        end
      end
      if (bus.wr_en) begin
        last_wr_cyc = cyc;
        if (wr_q.size() == 0) unexpected("wr", 32'(bus.wr_addr));
        else begin
          wr_t e;
          e = wr_q.pop_front();
          chk("wr_addr", 32'(bus.wr_addr), 32'(e.a));
          chk("wr_data", 32'(bus.wr_data), 32'(e.d));
        end
      end
    end
  end

  // Expected reads, columns and writes for one full frame.
  task automatic build_exp(input bit kernel_on);
    logic [AW-1:0] at, am, ab, a;
    cv_t c;
    for (int y = 1; y <= H - 2; y++) begin
      for (int x = 0; x < W; x++) begin
        at = AW'((y - 1) * W + x);
        am = AW'(y * W + x);
        ab = AW'((y + 1) * W + x);
        rd_q.push_back(at);
        rd_q.push_back(am);
        rd_q.push_back(ab);
        c.rs = (x == 0);
        c.t  = at[DW-1:0];
        c.m  = am[DW-1:0];
        c.b  = ab[DW-1:0];
        cv_q.push_back(c);
      end
    end
    if (kernel_on) begin
      for (int y = 1; y <= H - 2; y++) begin
        for (int x = 1; x <= W - 2; x++) begin
          a = AW'(y * W + x);
          wr_q.push_back({a, a[DW-1:0]});
        end
      end
    end
`ifdef SOBEL_BORDER_ZERO_EN
    for (int x = 0; x < W; x++) wr_q.push_back({AW'(x), 8'h00});
    for (int x = 0; x < W; x++) wr_q.push_back({AW'((H - 1) * W + x), 8'h00});
    for (int y = 1; y <= H - 2; y++) begin
      wr_q.push_back({AW'(y * W), 8'h00});
      wr_q.push_back({AW'(y * W + W - 1), 8'h00});
    end
`endif
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy_done"}, {30'h0, bus.busy, bus.done}, 32'h0);
    chk({tag, "_rd"}, {15'h0, bus.rd_en, bus.rd_addr}, 32'h0);
    chk({tag, "_col"}, {6'h0, bus.col_valid, bus.row_start, bus.col_top, bus.col_mid, bus.col_bot}, 32'h0);
    chk({tag, "_wr"}, {7'h0, bus.wr_en, bus.wr_addr, bus.wr_data}, 32'h0);
    chk({tag, "_err"}, 32'(bus.err), 32'h0);
  endtask

  task automatic run_frame(input string tag, input int l, input bit k,
                           input int exp_busy, input bit exp_err);
    int n;
    bit any_wr;
    lat = l;
    ken = k;
    build_exp(k);
    any_wr   = (wr_q.size() != 0);
    busy_cnt = 0;
    done_cnt = 0;
    @(posedge fclk); #1 bus.start = 1'b1;
    @(posedge fclk); #1 bus.start = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 1000) begin
      @(posedge fclk); #1;
      n++;
    end
    if (done_cnt == 0) unexpected({tag, "_done_timeout"}, 32'(n));
    repeat (3) @(posedge fclk);
    #1;
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({tag, "_busy_cyc"}, 32'(busy_cnt), 32'(exp_busy));
    chk({tag, "_err"}, 32'(bus.err), 32'(exp_err));
    chk({tag, "_wr_left"}, 32'(wr_q.size()), 32'd0);
    chk({tag, "_rd_left"}, 32'(rd_q.size()), 32'd0);
    chk({tag, "_col_left"}, 32'(cv_q.size()), 32'd0);
    if (any_wr) chk({tag, "_done_gap"}, 32'(done_cyc - last_wr_cyc), 32'd1);
  endtask

  initial begin
    bus.start = 1'b0;
    repeat (3) @(posedge fclk);
    #1 rst = 1'b0;
    check_zero("reset");

    // Kernel latency 1 and 3: identical writes, drain length differs.
    run_frame("lat1", 1, 1'b1, 4 * W * (H - 2) + 1 + BORDER_CYC, 1'b0);
    run_frame("lat3", 3, 1'b1, 4 * W * (H - 2) + 3 + BORDER_CYC, 1'b0);

    // Reset on cycle 17 of a frame, then replay the frame.
    lat = 1;
    ken = 1'b1;
    build_exp(1'b1);
    done_cnt = 0;
    @(posedge fclk); #1 bus.start = 1'b1;
    @(posedge fclk); #1 bus.start = 1'b0;
    repeat (16) @(posedge fclk);
    #1 rst = 1'b1;
    wr_q.delete();
    rd_q.delete();
    cv_q.delete();
    @(posedge fclk); #1 rst = 1'b0;
    check_zero("abort");
    repeat (50) @(posedge fclk);
    #1;
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    run_frame("replay", 1, 1'b1, 4 * W * (H - 2) + 1 + BORDER_CYC, 1'b0);

    // Silent kernel: no interior writes, sticky error, frame still completes.
    run_frame("nokern", 1, 1'b0, 4 * W * (H - 2) + 3 + BORDER_CYC, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
